noc_input_port: RTL and testbench
=================================

// Module: noc_input_port
// PURPOSE
// - Per-direction input stage of the 5-port NoC router: buffers incoming flits, decodes flit type,
//   computes XY output port from head flit, holds route for whole packet, presents flit+route to
//   switch allocator/crossbar. One instance per router input (L,N,E,S,W); sits between link and crossbar.
// PARAMETERS
// - FLIT_W   64  flit width; [63:62] type, [61:58] dest_x, [57:54] dest_y on head/single flits
// - DEPTH    4   FIFO entries; power of two, >=2
// - COORD_W  4   coordinate width
// PORTS
// - clk        in   1        clock; single domain
// - rst_n      in   1        reset, asynchronous assert, active-low
// - my_x       in   COORD_W  this router's X coordinate; static after reset
// - my_y       in   COORD_W  this router's Y coordinate; static after reset
// - flit_in    in   FLIT_W   upstream flit
// - valid_in   in   1        upstream flit valid
// - ready_out  out  1        may accept flit this cycle
// - flit_out   out  FLIT_W   flit at FIFO head
// - valid_out  out  1        flit_out valid for crossbar
// - ready_in   in   1        crossbar/allocator accepts flit_out
// - route_out  out  3        target output port: 0 L,1 N,2 E,3 S,4 W; valid while valid_out
// - pkt_head   out  1        flit_out starts a packet (head/single); allocator locks on it
// - pkt_tail   out  1        flit_out ends a packet (tail/single); allocator releases on it
// - err_pulse  out  1        one-cycle pulse on protocol error
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE, route_q=0; ready_out=1 after reset released; valid_out, pkt_head,
//   pkt_tail, err_pulse=0; flit_out=0.
// - Types: 00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE.
// - Push when valid_in&&ready_out; pop when valid_out&&ready_in. ready_out = !full (from registered
//   count, no same-cycle bypass; full FIFO with pop still deasserts ready_out that cycle).
// - Latency: flit pushed in cycle N is at flit_out earliest N+1; no combinational in->out path.
// - Simultaneous push+pop on non-full, non-empty FIFO: count unchanged, both pointers advance; wrap mod DEPTH.
// - Route (XY, X first): dest_x>my_x -> E; dest_x<my_x -> W; else dest_y>my_y -> N; dest_y<my_y -> S;
//   else L. Unsigned compare, COORD_W bits.
// - FSM IDLE/PKT. IDLE: route_out = XY(head entry), combinational from FIFO head + my_x/my_y.
//   IDLE, pop HEAD -> latch route_q, go PKT. IDLE, pop SINGLE -> stay IDLE.
//   PKT: route_out=route_q. PKT, pop TAIL -> IDLE. PKT, pop BODY -> stay.
// - Errors (err_pulse=1 the cycle after detection, one cycle):
//   * IDLE with BODY/TAIL at FIFO head: valid_out stays 0, entry discarded internally next cycle (drop).
//   * PKT with HEAD/SINGLE at FIFO head: forwarded as new packet; HEAD re-latches route_q (stays PKT),
//     SINGLE returns to IDLE. Allocator sees pkt_head and re-arbitrates.
// - valid_out=0 while a drop is pending; dropped flits never appear on flit_out.
// - ready_in low holds flit_out/route_out/pkt_* stable (no retraction of valid_out).
// - rst_n asserted mid-packet: FIFO flushed, FSM to IDLE immediately; partial packet lost, no err_pulse.
// CONFIGURATION
// - NOC_INPUT_PORT_STATS_EN defined: adds outputs stat_drop_cnt[15:0] (dropped flits, saturating at 0xFFFF)
//   and stat_hwm[$clog2(DEPTH):0] (max occupancy since reset); both reset to 0.
// - Not defined: ports absent, no counter logic; core behaviour identical.
// STRUCTURE
// - noc_pkg: flit_type_e, port_e (PORT_L..PORT_W), field offsets/widths for type/dest_x/dest_y,
//   function xy_route(dest_x,dest_y,my_x,my_y).
// - Sub-module noc_sync_fifo (FLIT_W, DEPTH): ptrs, count, full/empty; FSM+routing stay in noc_input_port.
// TESTING
// - my=(2,2); SINGLE dest (5,1), ready_in=1 -> valid_out cycle after push, route_out=E, pkt_head=pkt_tail=1.
// - HEAD dest(2,0), 2 BODY, TAIL -> all 4 flits route_out=S, pkt_head only 1st, pkt_tail only 4th, back IDLE.
// - ready_in=0, push 4 flits (DEPTH=4) -> ready_out=0 after 4th; 5th valid_in not accepted; ready_in=1
//   -> drains in order, ready_out=1 cycle after first pop.
// - IDLE, push BODY then SINGLE dest(2,2) -> BODY never on flit_out, err_pulse once, SINGLE out route L.
// - HEAD dest(0,2) (W), BODY, then HEAD dest(2,3) -> err_pulse, second packet route_out=N.
// - rst_n low 1 cycle mid-packet with 3 flits queued -> valid_out=0, ready_out=1, next HEAD routed fresh.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: flit type and router port encodings, flit field layout
// and the dimension-ordered (X then Y) routing function.
package noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_L = 3'd0,
    PORT_N = 3'd1,
    PORT_E = 3'd2,
    PORT_S = 3'd3,
    PORT_W = 3'd4
  } port_e;

  // Field layout is fixed relative to the flit MSB: type, dest_x, dest_y.
  localparam int unsigned TYPE_W      = 2;
  localparam int unsigned COORD_MAX_W = 8;

  function automatic port_e xy_route(input logic [COORD_MAX_W-1:0] dest_x,
                                     input logic [COORD_MAX_W-1:0] dest_y,
                                     input logic [COORD_MAX_W-1:0] my_x,
                                     input logic [COORD_MAX_W-1:0] my_y);
    port_e p;
    if (dest_x > my_x)      p = PORT_E;
    else if (dest_x < my_x) p = PORT_W;
    else if (dest_y > my_y) p = PORT_N;
    else if (dest_y < my_y) p = PORT_S;
    else                    p = PORT_L;
    return p;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
module noc_sync_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// Router input stage: flit FIFO, XY route decode and packet-framing FSM.
// Optional NOC_INPUT_PORT_STATS_EN adds drop counter and occupancy high-water mark.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int unsigned FLIT_W  = 64,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned COORD_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COORD_W-1:0]      my_x,
  input  logic [COORD_W-1:0]      my_y,
  input  logic [FLIT_W-1:0]       flit_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [FLIT_W-1:0]       flit_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [2:0]              route_out,
  output logic                    pkt_head,
  output logic                    pkt_tail,
  output logic                    err_pulse
`ifdef NOC_INPUT_PORT_STATS_EN
  ,
  output logic [15:0]             stat_drop_cnt,
  output logic [$clog2(DEPTH):0]  stat_hwm
`endif
);

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned DX_LSB = FLIT_W - TYPE_W - COORD_W;
  localparam int unsigned DY_LSB = DX_LSB - COORD_W;

  typedef enum logic {ST_IDLE, ST_PKT} state_e;

  state_e      state_q;
  port_e       route_q;
  logic        err_q;

  logic [FLIT_W-1:0] head;
  logic              empty, full;
  logic [CW-1:0]     count;
  flit_type_e        head_type;
  port_e             xy;
  logic              starts, ends, drop, fwd, push, pop;

  noc_sync_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (flit_in),
    .dout_o  (head),
    .empty_o (empty),
    .count_o (count)
  );

  assign head_type = flit_type_e'(head[FLIT_W-1 -: TYPE_W]);
  assign starts    = (head_type == FT_HEAD) || (head_type == FT_SINGLE);
  assign ends      = (head_type == FT_TAIL) || (head_type == FT_SINGLE);
  assign xy        = xy_route(COORD_MAX_W'(head[DX_LSB +: COORD_W]),
                              COORD_MAX_W'(head[DY_LSB +: COORD_W]),
                              COORD_MAX_W'(my_x), COORD_MAX_W'(my_y));

  // An orphan body/tail at the head while idle is popped silently and never shown.
  assign drop      = !empty && (state_q == ST_IDLE) && !starts;
  assign full      = (count == CW'(DEPTH));
  assign ready_out = !full;
  assign push      = valid_in && !full;
  assign valid_out = !empty && !drop;
  assign fwd       = valid_out && ready_in;
  assign pop       = fwd || drop;

  assign flit_out  = valid_out ? head : '0;
  assign route_out = (valid_out && starts) ? xy : route_q;
  assign pkt_head  = valid_out && starts;
  assign pkt_tail  = valid_out && ends;
  assign err_pulse = err_q;

  // A head/single arriving mid-packet starts a fresh packet; flagged but still forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      route_q <= PORT_L;
      err_q   <= 1'b0;
    end else begin
      err_q <= drop || (fwd && (state_q == ST_PKT) && starts);
      if (fwd) begin
        case (head_type)
          FT_HEAD: begin
            state_q <= ST_PKT;
            route_q <= xy;
          end
          FT_SINGLE, FT_TAIL: state_q <= ST_IDLE;
          default:            state_q <= state_q;
        endcase
      end
    end
  end

`ifdef NOC_INPUT_PORT_STATS_EN
  logic [15:0]   drop_cnt_q;
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (count > hwm_q) hwm_q <= count;
    end
  end

  assign stat_drop_cnt = drop_cnt_q;
  assign stat_hwm      = hwm_q;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port: vector table plus scoreboarded corner sequences.
module tb_noc_input_port;
  import noc_pkg::*;

  localparam int unsigned FLIT_W  = 64;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned COORD_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        my_x, my_y;
  logic [63:0]       flit_in;
  logic              valid_in, ready_out;
  logic [63:0]       flit_out;
  logic              valid_out, ready_in;
  logic [2:0]        route_out;
  logic              pkt_head, pkt_tail, err_pulse;
`ifdef NOC_INPUT_PORT_STATS_EN
  logic [15:0]       stat_drop_cnt;
  logic [2:0]        stat_hwm;
`endif

  always #5 clk = ~clk;

  noc_input_port #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .COORD_W(COORD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .my_x      (my_x),
    .my_y      (my_y),
    .flit_in   (flit_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .flit_out  (flit_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .route_out (route_out),
    .pkt_head  (pkt_head),
    .pkt_tail  (pkt_tail),
    .err_pulse (err_pulse)
`ifdef NOC_INPUT_PORT_STATS_EN
    ,
    .stat_drop_cnt (stat_drop_cnt),
    .stat_hwm      (stat_hwm)
`endif
  );

  typedef struct packed {
    logic [63:0] flit;
    logic [2:0]  route;
    logic        head;
    logic        tail;
  } exp_t;

  exp_t sbq[$];
  exp_t tbl[14];
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;
  int   e0;

  function automatic logic [63:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic [53:0] pl);
    return {t, dx, dy, pl};
  endfunction

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_pulse) err_seen++;
        if (valid_out && ready_in) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got flit %h route %0d expected no output", flit_out, route_out);
          end else begin
            e = sbq.pop_front();
            chk("sb_flit", {11'b0, flit_out, route_out, pkt_head, pkt_tail}, {11'b0, e});
          end
        end
      end
    end
  endtask

  task automatic send(input logic [63:0] f, input logic keep, input logic [2:0] r,
                      input logic h, input logic t);
    int n;
    exp_t e;
    @(negedge clk);
    flit_in  = f;
    valid_in = 1'b1;
    n = 0;
    while (!ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_out 0 expected 1");
      valid_in = 1'b0;
      return;
    end
    if (keep) begin
      e.flit = f; e.route = r; e.head = h; e.tail = t;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || valid_out) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 80'(sbq.size()), 80'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    flit_in  = '0;
    ready_in = 1'b1;
    my_x     = 4'd2;
    my_y     = 4'd2;

    tbl[0]  = '{mk(FT_SINGLE, 4'd5,  4'd1,  54'h11), PORT_E, 1'b1, 1'b1};
    tbl[1]  = '{mk(FT_HEAD,   4'd2,  4'd0,  54'h21), PORT_S, 1'b1, 1'b0};
    tbl[2]  = '{mk(FT_BODY,   4'd0,  4'd0,  54'h22), PORT_S, 1'b0, 1'b0};
    tbl[3]  = '{mk(FT_BODY,   4'd9,  4'd9,  54'h23), PORT_S, 1'b0, 1'b0};
    tbl[4]  = '{mk(FT_TAIL,   4'd7,  4'd7,  54'h24), PORT_S, 1'b0, 1'b1};
    tbl[5]  = '{mk(FT_SINGLE, 4'd2,  4'd5,  54'h31), PORT_N, 1'b1, 1'b1};
    tbl[6]  = '{mk(FT_SINGLE, 4'd0,  4'd3,  54'h32), PORT_W, 1'b1, 1'b1};
    tbl[7]  = '{mk(FT_SINGLE, 4'd2,  4'd2,  54'h33), PORT_L, 1'b1, 1'b1};
    tbl[8]  = '{mk(FT_SINGLE, 4'd15, 4'd0,  54'h34), PORT_E, 1'b1, 1'b1};
    tbl[9]  = '{mk(FT_SINGLE, 4'd2,  4'd15, 54'h35), PORT_N, 1'b1, 1'b1};
    tbl[10] = '{mk(FT_SINGLE, 4'd2,  4'd0,  54'h36), PORT_S, 1'b1, 1'b1};
    tbl[11] = '{mk(FT_SINGLE, 4'd1,  4'd15, 54'h37), PORT_W, 1'b1, 1'b1};
    tbl[12] = '{mk(FT_HEAD,   4'd3,  4'd3,  54'h41), PORT_E, 1'b1, 1'b0};
    tbl[13] = '{mk(FT_TAIL,   4'd0,  4'd2,  54'h42), PORT_E, 1'b0, 1'b1};

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 80'(ready_out), 80'(1));
    chk("reset_outs", {flit_out, route_out, valid_out, pkt_head, pkt_tail, err_pulse}, '0);

    // Table vectors, back to back with the crossbar always ready
    for (int i = 0; i < 14; i++)
      send(tbl[i].flit, 1'b1, tbl[i].route, tbl[i].head, tbl[i].tail);
    drain();

    // First-flit latency: visible the cycle after the push
    send(mk(FT_SINGLE, 4'd3, 4'd2, 54'h51), 1'b1, PORT_E, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_valid", 80'(valid_out), 80'(1));
    chk("lat_route", 80'(route_out), 80'(PORT_E));
    drain();

    // Fill with crossbar stalled, refused fifth flit, then drain
    @(posedge clk);
    #1 ready_in = 1'b0;
    send(mk(FT_SINGLE, 4'd4, 4'd2, 54'h61), 1'b1, PORT_E, 1'b1, 1'b1);
    send(mk(FT_SINGLE, 4'd1, 4'd2, 54'h62), 1'b1, PORT_W, 1'b1, 1'b1);
    send(mk(FT_SINGLE, 4'd2, 4'd4, 54'h63), 1'b1, PORT_N, 1'b1, 1'b1);
    send(mk(FT_SINGLE, 4'd2, 4'd1, 54'h64), 1'b1, PORT_S, 1'b1, 1'b1);
    @(negedge clk);
    chk("full_ready", 80'(ready_out), 80'(0));
    chk("stall_hold0", {15'b0, valid_out, flit_out}, {15'b0, 1'b1, mk(FT_SINGLE, 4'd4, 4'd2, 54'h61)});
    flit_in  = mk(FT_SINGLE, 4'd2, 4'd2, 54'h6F);
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    chk("stall_hold1", {15'b0, valid_out, flit_out}, {15'b0, 1'b1, mk(FT_SINGLE, 4'd4, 4'd2, 54'h61)});
    @(posedge clk);
    #1 ready_in = 1'b1;
    @(negedge clk);
    chk("ready_pop_cycle", 80'(ready_out), 80'(0));
    @(negedge clk);
    chk("ready_after_pop", 80'(ready_out), 80'(1));
    drain();

    // Orphan body while idle is dropped, following single still delivered
    e0 = err_seen;
    send(mk(FT_BODY, 4'd5, 4'd5, 54'h71), 1'b0, PORT_L, 1'b0, 1'b0);
    send(mk(FT_SINGLE, 4'd2, 4'd2, 54'h72), 1'b1, PORT_L, 1'b1, 1'b1);
    drain();
    chk("drop_err", 80'(err_seen - e0), 80'(1));

    // New head mid-packet: forwarded, re-routed, flagged once
    e0 = err_seen;
    send(mk(FT_HEAD, 4'd0, 4'd2, 54'h81), 1'b1, PORT_W, 1'b1, 1'b0);
    send(mk(FT_BODY, 4'd5, 4'd5, 54'h82), 1'b1, PORT_W, 1'b0, 1'b0);
    send(mk(FT_HEAD, 4'd2, 4'd3, 54'h83), 1'b1, PORT_N, 1'b1, 1'b0);
    send(mk(FT_TAIL, 4'd0, 4'd0, 54'h84), 1'b1, PORT_N, 1'b0, 1'b1);
    drain();
    chk("pkt_err", 80'(err_seen - e0), 80'(1));

    // Reset mid-packet with three body flits queued
    send(mk(FT_HEAD, 4'd4, 4'd4, 54'h91), 1'b1, PORT_E, 1'b1, 1'b0);
    drain();
    @(posedge clk);
    #1 ready_in = 1'b0;
    for (int i = 0; i < 3; i++)
      send(mk(FT_BODY, 4'd0, 4'd0, 54'h92 + 54'(i)), 1'b0, PORT_E, 1'b0, 1'b0);
    e0 = err_seen;
    @(posedge clk);
    #1 rst_n = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 80'(valid_out), 80'(0));
    chk("rst_ready", 80'(ready_out), 80'(1));
    send(mk(FT_BODY, 4'd5, 4'd5, 54'hA1), 1'b0, PORT_L, 1'b0, 1'b0);
    send(mk(FT_HEAD, 4'd2, 4'd1, 54'hA2), 1'b1, PORT_S, 1'b1, 1'b0);
    send(mk(FT_TAIL, 4'd9, 4'd9, 54'hA3), 1'b1, PORT_S, 1'b0, 1'b1);
    drain();
    chk("rst_err", 80'(err_seen - e0), 80'(1));

    chk("sb_empty", 80'(sbq.size()), 80'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
